conv1_ofm_writer: RTL and testbench

- Downstream neighbour of the first conv layer.
- Captures each 64-channel output vector on conv1_sample, buffers up to two vectors, and serialises them into the layer-1 feature-map RAM, LANES channels per write beat, in channel-group-planar layout.
- Raises ram_feedback once all WOUT*WOUT pixels are stored, which tells the conv layer that its output has been committed.

---
 rtl/conv_pkg.sv | 8 +
 rtl/ofm_vec_fifo2.sv | 40 ++++
 rtl/conv1_ofm_writer.sv | 98 +++++++++
 tb/tb_conv1_ofm_writer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults and types for the conv1 output-feature-map writer.
package conv_pkg;
    localparam int WIDTH = 16;
    localparam int LANES = 4;
    localparam int CHOUT = 64;
    typedef logic [WIDTH-1:0] fm_word_t;
    typedef enum logic [1:0] {IDLE, DRAIN, DONE} wr_state_t;
endpackage

// File: rtl/ofm_vec_fifo2.sv
// ofm_vec_fifo2: two-entry FIFO of flattened channel vectors.
// The caller only asserts i_push when an entry is free or being popped.
module ofm_vec_fifo2 #(
    parameter int W = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count,
    output logic         o_full
);
    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_count == 2'd2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) r_wr_ptr <= !r_wr_ptr;
            if (i_pop) r_rd_ptr <= !r_rd_ptr;
            r_count <= r_count + 2'(i_push) - 2'(i_pop);
        end
    end

    // Payload needs no reset: validity is carried by r_count.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/conv1_ofm_writer.sv
// conv1_ofm_writer: buffers conv1 output vectors and writes them LANES channels
// per beat into the layer-1 feature-map RAM in channel-group-planar layout.
module conv1_ofm_writer #(
    parameter int WOUT  = 128,
    parameter int CHOUT = conv_pkg::CHOUT,
    parameter int WIDTH = conv_pkg::WIDTH,
    parameter int LANES = conv_pkg::LANES,
    localparam int BEATS  = CHOUT / LANES,
    localparam int NPIX   = WOUT * WOUT,
    localparam int PIX_W  = $clog2(NPIX),
    localparam int BEAT_W = $clog2(BEATS),
    localparam int ADDR_W = $clog2(NPIX * BEATS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     conv1_sample,
    input  logic                     conv1_finish,
    input  logic [WIDTH-1:0]         ofm [CHOUT],
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [LANES*WIDTH-1:0]   ram_wdata,
    output logic                     ram_feedback,
    output logic                     busy,
    output logic                     overflow,
    output logic                     extra_sample
);
    import conv_pkg::*;

    wr_state_t                r_state;
    logic [BEAT_W-1:0]        r_beat;
    logic [PIX_W-1:0]         r_pixel;
    logic [CHOUT*WIDTH-1:0]   w_vec;
    logic [CHOUT*WIDTH-1:0]   w_head;
    logic [1:0]               w_count;
    logic [1:0]               w_left;
    logic                     w_full;
    logic                     w_issue;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_accept;
    logic                     w_unused;

    for (genvar g = 0; g < CHOUT; g++) begin : g_pack
        assign w_vec[g*WIDTH +: WIDTH] = ofm[g];
    end

    // conv1_finish is informational; control flow ignores it.
    assign w_unused = conv1_finish;

    assign w_issue  = r_state != DONE && w_count != 2'd0;
    assign w_pop    = w_issue && r_beat == BEAT_W'(BEATS - 1);
    assign w_push   = conv1_sample && r_state != DONE;
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_left   = w_count - 2'(w_pop) + 2'(w_accept);
    assign busy     = w_count != 2'd0 || r_state == DRAIN;

    ofm_vec_fifo2 #(.W(CHOUT * WIDTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_data  (w_vec),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_pixel      <= '0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_feedback <= 1'b0;
            overflow     <= 1'b0;
            extra_sample <= 1'b0;
        end else begin
            ram_we <= w_issue;
            // Beat-major planes: addr = beat * WOUT*WOUT + pixel.
            if (w_issue) begin
                ram_addr  <= (ADDR_W'(r_beat) << PIX_W) | ADDR_W'(r_pixel);
                ram_wdata <= w_head[int'(r_beat)*LANES*WIDTH +: LANES*WIDTH];
                r_beat    <= w_pop ? '0 : r_beat + 1'b1;
            end
            if (w_pop) begin
                r_pixel <= r_pixel + PIX_W'(r_pixel != PIX_W'(NPIX - 1));
                r_state <= r_pixel == PIX_W'(NPIX - 1) ? DONE : (w_left != 2'd0 ? DRAIN : IDLE);
            end else if (w_issue) begin
                r_state <= DRAIN;
            end
            ram_feedback <= ram_feedback || r_state == DONE;
            overflow     <= overflow || (w_push && w_full && !w_pop);
            extra_sample <= extra_sample || (conv1_sample && r_state == DONE);
        end
    end
endmodule

// File: tb/tb_conv1_ofm_writer.sv
// tb_conv1_ofm_writer: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations (WOUT=16 keeps the full frame short).
module tb_conv1_ofm_writer;
    import conv_pkg::*;

    localparam int WOUT   = 16;
    localparam int NPIX   = WOUT * WOUT;
    localparam int BEATS  = CHOUT / LANES;
    localparam int ADDR_W = $clog2(NPIX * BEATS);
    localparam int VW     = CHOUT * WIDTH;
    localparam int BW     = LANES * WIDTH;

    logic clk = 0;
    logic rst = 0;
    logic conv1_sample = 0;
    logic conv1_finish = 0;
    fm_word_t ofm [CHOUT];
    logic ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [BW-1:0] ram_wdata;
    logic ram_feedback, busy, overflow, extra_sample;

    conv1_ofm_writer #(.WOUT(WOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .conv1_sample (conv1_sample),
        .conv1_finish (conv1_finish),
        .ofm          (ofm),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_feedback (ram_feedback),
        .busy         (busy),
        .overflow     (overflow),
        .extra_sample (extra_sample)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int s_cyc = 0;
    int fb_cyc = -1;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack_ofm();
        logic [VW-1:0] v;
        for (int i = 0; i < CHOUT; i++) v[i*WIDTH +: WIDTH] = ofm[i];
        return v;
    endfunction

    function automatic logic [BW-1:0] grp(input int seed, input int g);
        logic [BW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*WIDTH +: WIDTH] = WIDTH'(seed * 256 + g * LANES + l + 1);
        return v;
    endfunction

    // Reference model: each vector occupies BEATS consecutive write slots once
    // it reaches the head of a two-deep queue; writes appear one edge after issue.
    logic [VW-1:0] q[$];
    int k = 0;
    int pix = 0;
    bit done = 0;
    bit was_done = 0;
    logic e_we = 0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [BW-1:0] e_data = '0;
    bit e_fb = 0, e_ovf = 0, e_extra = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            k = 0; pix = 0; done = 0;
            e_we = 0; e_addr = '0; e_data = '0;
            e_fb = 0; e_ovf = 0; e_extra = 0;
        end else begin
            was_done = done;
            e_fb = e_fb | was_done;
            e_we = 0;
            if (!was_done && q.size() > 0) begin
                e_we = 1;
                e_addr = ADDR_W'(k * NPIX + pix);
                e_data = q[0][k*BW +: BW];
                k++;
                if (k == BEATS) begin
                    void'(q.pop_front());
                    k = 0;
                    pix++;
                    done = pix == NPIX;
                end
            end
            if (conv1_sample) begin
                if (was_done) e_extra = 1;
                else if (q.size() < 2) q.push_back(pack_ofm());
                else e_ovf = 1;
            end
        end
    end

    typedef struct {int c; logic [ADDR_W-1:0] a; logic [BW-1:0] d;} wr_t;
    wr_t wlog[$];

    always @(negedge clk) begin
        chk("ram_we", 64'(ram_we), 64'(e_we));
        if (e_we) begin
            chk("ram_addr", 64'(ram_addr), 64'(e_addr));
            chk("ram_wdata", 64'(ram_wdata), 64'(e_data));
        end
        chk("busy", 64'(busy), 64'(q.size() != 0));
        chk("ram_feedback", 64'(ram_feedback), 64'(e_fb));
        chk("overflow", 64'(overflow), 64'(e_ovf));
        chk("extra_sample", 64'(extra_sample), 64'(e_extra));
        if (ram_we) wlog.push_back('{cyc, ram_addr, ram_wdata});
        if (ram_feedback && fb_cyc < 0) fb_cyc = cyc;
    end

    task automatic set_vec(input int seed);
        for (int i = 0; i < CHOUT; i++) ofm[i] = WIDTH'(seed * 256 + i + 1);
    endtask

    task automatic do_reset();
        rst = 0;
        conv1_sample = 0;
        conv1_finish = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        wlog.delete();
        fb_cyc = -1;
    endtask

    task automatic pulse(input int seed, input bit fin);
        @(posedge clk);
        #1 set_vec(seed);
        conv1_sample = 1;
        conv1_finish = fin;
        s_cyc = cyc;
        @(posedge clk);
        #1 conv1_sample = 0;
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, "_we"}, 64'(ram_we), 0);
        chk({tag, "_addr"}, 64'(ram_addr), 0);
        chk({tag, "_wdata"}, 64'(ram_wdata), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_fb"}, 64'(ram_feedback), 0);
        chk({tag, "_ovf"}, 64'(overflow), 0);
        chk({tag, "_extra"}, 64'(extra_sample), 0);
    endtask

    int n;
    bit found;

    initial begin
        set_vec(0);

        // Single pixel
        do_reset();
        zero_outputs("t1_reset");
        pulse(0, 0);
        repeat (20) @(posedge clk);
        #1 chk("t1_nwrites", wlog.size(), 16);
        if (wlog.size() == 16) begin
            chk("t1_latency", wlog[0].c - s_cyc, 2);
            chk("t1_addr0", 64'(wlog[0].a), 0);
            chk("t1_data0", 64'(wlog[0].d), 64'h0004_0003_0002_0001);
            chk("t1_addr15", 64'(wlog[15].a), 3840);
            chk("t1_data15", 64'(wlog[15].d), 64'h0040_003f_003e_003d);
            chk("t1_contig", wlog[15].c - wlog[0].c, 15);
        end
        chk("t1_busy", 64'(busy), 0);

        // Back-to-back samples in consecutive cycles
        do_reset();
        @(posedge clk);
        #1 set_vec(1); conv1_sample = 1;
        @(posedge clk);
        #1 set_vec(2);
        @(posedge clk);
        #1 conv1_sample = 0;
        repeat (40) @(posedge clk);
        #1 chk("t2_nwrites", wlog.size(), 32);
        if (wlog.size() == 32) begin
            chk("t2_contig", wlog[31].c - wlog[0].c, 31);
            chk("t2_b_addr", 64'(wlog[16].a), 1);
            chk("t2_b_data", 64'(wlog[16].d), 64'(grp(2, 0)));
        end
        chk("t2_ovf", 64'(overflow), 0);

        // Overflow: third of three consecutive samples dropped
        do_reset();
        @(posedge clk);
        #1 set_vec(3); conv1_sample = 1;
        @(posedge clk);
        #1 set_vec(4);
        @(posedge clk);
        #1 set_vec(5);
        @(posedge clk);
        #1 conv1_sample = 0;
        repeat (50) @(posedge clk);
        #1 chk("t3_ovf", 64'(overflow), 1);
        chk("t3_nwrites", wlog.size(), 32);
        pulse(6, 0);
        repeat (25) @(posedge clk);
        #1 chk("t3_nwrites2", wlog.size(), 48);
        if (wlog.size() == 48) begin
            chk("t3_next_addr", 64'(wlog[32].a), 2);
            chk("t3_next_data", 64'(wlog[32].d), 64'(grp(6, 0)));
        end

        // Push coincident with pop while full: accepted
        do_reset();
        @(posedge clk);
        #1 set_vec(7); conv1_sample = 1;
        @(posedge clk);
        #1 set_vec(8);
        @(posedge clk);
        #1 conv1_sample = 0;
        repeat (14) @(posedge clk);
        #1 set_vec(9); conv1_sample = 1;
        @(posedge clk);
        #1 conv1_sample = 0;
        repeat (60) @(posedge clk);
        #1 chk("t4_ovf", 64'(overflow), 0);
        chk("t4_nwrites", wlog.size(), 48);
        if (wlog.size() == 48) begin
            chk("t4_g_addr", 64'(wlog[32].a), 2);
            chk("t4_g_data", 64'(wlog[32].d), 64'(grp(9, 0)));
            chk("t4_contig", wlog[47].c - wlog[0].c, 47);
        end

        // Same, one cycle early: buffer still full without a pop, so dropped
        do_reset();
        @(posedge clk);
        #1 set_vec(7); conv1_sample = 1;
        @(posedge clk);
        #1 set_vec(8);
        @(posedge clk);
        #1 conv1_sample = 0;
        repeat (13) @(posedge clk);
        #1 set_vec(9); conv1_sample = 1;
        @(posedge clk);
        #1 conv1_sample = 0;
        repeat (60) @(posedge clk);
        #1 chk("t4b_ovf", 64'(overflow), 1);
        chk("t4b_nwrites", wlog.size(), 32);

        // Async reset at beat 7 of pixel 5
        do_reset();
        for (int p = 0; p < 6; p++) begin
            pulse(10 + p, 0);
            if (p < 5) repeat (26) @(posedge clk);
        end
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = ram_we && ram_addr == ADDR_W'(7 * NPIX + 5);
        end
        chk("t5_reach_beat7", 64'(found), 1);
        #2 rst = 0;
        #1 zero_outputs("t5_async");
        @(negedge clk);
        #2 rst = 1;
        wlog.delete();
        pulse(20, 0);
        repeat (20) @(posedge clk);
        #1 chk("t5_nwrites", wlog.size(), 16);
        if (wlog.size() == 16) begin
            chk("t5_addr0", 64'(wlog[0].a), 0);
            chk("t5_data0", 64'(wlog[0].d), 64'(grp(20, 0)));
        end

        // Full frame at 28-cycle spacing; last sample coincides with conv1_finish
        do_reset();
        for (int p = 0; p < NPIX; p++) begin
            pulse(p % 200, p == NPIX - 1);
            conv1_finish = 0;
            repeat (26) @(posedge clk);
        end
        repeat (30) @(posedge clk);
        #1 chk("t6_nwrites", wlog.size(), NPIX * BEATS);
        if (wlog.size() > 0) begin
            chk("t6_last_addr", 64'(wlog[$].a), 4095);
            chk("t6_fb_delay", fb_cyc - wlog[$].c, 1);
        end
        chk("t6_fb", 64'(ram_feedback), 1);
        chk("t6_busy", 64'(busy), 0);
        chk("t6_ovf", 64'(overflow), 0);
        n = wlog.size();
        pulse(1, 0);
        repeat (10) @(posedge clk);
        #1 chk("t6_extra", 64'(extra_sample), 1);
        chk("t6_no_write", wlog.size(), n);
        chk("t6_fb_sticky", 64'(ram_feedback), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
